// File: rtl/ps2_keycode_src.sv
// ps2_keycode_src
//
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop), decodes scan code set 2 make/break sequences and presents the HID
// code of the currently held mapped key.
//
// Parameters:
//   TIMEOUT_CYCLES  Clk cycles without a PS/2 falling edge before an
//                   in-progress frame is abandoned.
//
// Configuration macro:
//   PS2_ARROW_KEYS_EN  when defined, the E0-prefixed arrow keys are mapped
//                      (E0 75/72/6B/74 -> 0x1A/0x16/0x04/0x07).
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      synchronous, active-high
//   PS2_CLK    keyboard clock, asynchronous, idles high
//   PS2_DAT    keyboard data, asynchronous, idles high
//   keycode    HID code of the held mapped key, 0x00 when none
//   key_event  one-cycle pulse whenever keycode changes
//   frame_err  one-cycle pulse on parity, start/stop or timeout error
//
// Receiver states:
//   RX_IDLE   | waiting for a start bit
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | checking the odd parity bit
//   RX_STOP   | checking the stop bit, releasing the byte
//
// Decoder states:
//   DEC_BASE     | no prefix seen
//   DEC_GOT_E0   | extended prefix seen
//   DEC_GOT_F0   | break prefix seen
//   DEC_GOT_E0F0 | extended break prefix seen

module ps2_keycode_src #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       frame_err
);

    localparam logic [31:0] TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_BASE, DEC_GOT_E0, DEC_GOT_F0, DEC_GOT_E0F0} dec_state_t;

    logic        clk_s1, clk_s2, clk_prev;
    logic        dat_s1, dat_s2;
    logic        ps2_fall;

    rx_state_t   rx_state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [31:0] idle_cnt;
    logic        parity_err;
    logic        byte_valid;

    dec_state_t  dec_state, dec_next;
    logic [7:0]  hid;
    logic        is_make, is_break;

    function automatic logic [7:0] map_base(input logic [7:0] code);
        case (code)
            8'h1D:   map_base = 8'h1A;
            8'h1C:   map_base = 8'h04;
            8'h1B:   map_base = 8'h16;
            8'h23:   map_base = 8'h07;
            8'h5A:   map_base = 8'h28;
            8'h76:   map_base = 8'h29;
            default: map_base = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] map_ext(input logic [7:0] code);
`ifdef PS2_ARROW_KEYS_EN
        case (code)
            8'h75:   map_ext = 8'h1A;
            8'h72:   map_ext = 8'h16;
            8'h6B:   map_ext = 8'h04;
            8'h74:   map_ext = 8'h07;
            default: map_ext = 8'h00;
        endcase
`else
        map_ext = (code == code) ? 8'h00 : 8'h00;
`endif
    endfunction

    // Synchronizers; clk_prev holds the previous synchronized clock for
    // edge detection.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
        end
    end

    assign ps2_fall = clk_prev & ~clk_s2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            idle_cnt   <= 32'd0;
            parity_err <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_state == RX_IDLE) begin
                idle_cnt <= 32'd0;
                if (ps2_fall) begin
                    if (!dat_s2) begin
                        rx_state   <= RX_DATA;
                        bit_cnt    <= 3'd0;
                        shift_reg  <= 8'h00;
                        parity_err <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (ps2_fall) begin
                idle_cnt <= 32'd0;
                case (rx_state)
                    RX_DATA: begin
                        shift_reg <= {dat_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            rx_state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        // Odd parity: data bits plus parity bit must XOR to 1.
                        parity_err <= ~(^shift_reg ^ dat_s2);
                        rx_state   <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (dat_s2 && !parity_err)
                            byte_valid <= 1'b1;
                        else
                            frame_err <= 1'b1;
                        rx_state <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end else if (idle_cnt >= TIMEOUT_VAL) begin
                rx_state  <= RX_IDLE;
                idle_cnt  <= 32'd0;
                frame_err <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end

    // The received byte stays in shift_reg while byte_valid is high, since
    // the shift register is only cleared by the next start bit.
    always_comb begin
        dec_next = dec_state;
        hid      = 8'h00;
        is_make  = 1'b0;
        is_break = 1'b0;
        if (byte_valid) begin
            case (dec_state)
                DEC_BASE: begin
                    if (shift_reg == 8'hE0)
                        dec_next = DEC_GOT_E0;
                    else if (shift_reg == 8'hF0)
                        dec_next = DEC_GOT_F0;
                    else begin
                        hid     = map_base(shift_reg);
                        is_make = 1'b1;
                    end
                end
                DEC_GOT_E0: begin
                    if (shift_reg == 8'hF0)
                        dec_next = DEC_GOT_E0F0;
                    else begin
                        hid      = map_ext(shift_reg);
                        is_make  = 1'b1;
                        dec_next = DEC_BASE;
                    end
                end
                DEC_GOT_F0: begin
                    hid      = map_base(shift_reg);
                    is_break = 1'b1;
                    dec_next = DEC_BASE;
                end
                default: begin
                    hid      = map_ext(shift_reg);
                    is_break = 1'b1;
                    dec_next = DEC_BASE;
                end
            endcase
        end
    end

    // hid of 0x00 means unmapped; such codes leave keycode untouched.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dec_state <= DEC_BASE;
            keycode   <= 8'h00;
            key_event <= 1'b0;
        end else begin
            dec_state <= dec_next;
            key_event <= 1'b0;
            if (is_make && hid != 8'h00 && hid != keycode) begin
                keycode   <= hid;
                key_event <= 1'b1;
            end else if (is_break && hid != 8'h00 && keycode == hid) begin
                keycode   <= 8'h00;
                key_event <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_src.sv
// tb_ps2_keycode_src
//
// Drives PS/2 frames (directed and random) into ps2_keycode_src and compares
// keycode, key_event and frame_err activity against a byte-level model of
// the make/break rules.

module tb_ps2_keycode_src;

    localparam int unsigned TMO = 300;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] keycode;
    logic       key_event;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    int exp_ev = 0;
    int exp_err = 0;
    logic [7:0] exp_kc = 8'h00;
    int prefix = 0;          // 0 none, 1 E0, 2 F0, 3 E0 F0
    logic [7:0] prev_kc = 8'h00;

    ps2_keycode_src #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keycode   (keycode),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            if (key_event) ev_cnt++;
            if (frame_err) err_cnt++;
            if (key_event || frame_err)
                check("ev_err_excl", 32'(key_event & frame_err), 0);
            if (key_event || keycode != prev_kc)
                check("ev_on_change", 32'(key_event), 32'(keycode != prev_kc));
        end
        prev_kc = keycode;
    end

    function automatic logic [7:0] ref_base(input logic [7:0] b);
        case (b)
            8'h1D: return 8'h1A;
            8'h1C: return 8'h04;
            8'h1B: return 8'h16;
            8'h23: return 8'h07;
            8'h5A: return 8'h28;
            8'h76: return 8'h29;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ref_ext(input logic [7:0] b);
`ifdef PS2_ARROW_KEYS_EN
        case (b)
            8'h75: return 8'h1A;
            8'h72: return 8'h16;
            8'h6B: return 8'h04;
            8'h74: return 8'h07;
            default: return 8'h00;
        endcase
`else
        return (b == 8'h00) ? 8'h00 : 8'h00;
`endif
    endfunction

    task automatic model_press(input logic [7:0] h);
        if (h != 8'h00 && h != exp_kc) begin
            exp_kc = h;
            exp_ev++;
        end
    endtask

    task automatic model_release(input logic [7:0] h);
        if (h != 8'h00 && exp_kc == h) begin
            exp_kc = 8'h00;
            exp_ev++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (prefix)
            0: if (b == 8'hE0) prefix = 1;
               else if (b == 8'hF0) prefix = 2;
               else model_press(ref_base(b));
            1: if (b == 8'hF0) prefix = 3;
               else begin model_press(ref_ext(b)); prefix = 0; end
            2: begin model_release(ref_base(b)); prefix = 0; end
            default: begin model_release(ref_ext(b)); prefix = 0; end
        endcase
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge Clk);
        PS2_DAT = b;
        repeat (3) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (6) @(negedge Clk);
        PS2_CLK = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    // kind: 0 good, 1 wrong parity, 2 wrong stop bit.
    // measure: count Clk edges from the stop-bit fall to key_event.
    task automatic send_frame(input logic [7:0] b, input int kind, input bit measure);
        logic par;
        int n;
        par = ~(^b);
        if (kind == 1) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        @(negedge Clk);
        PS2_DAT = (kind == 2) ? 1'b0 : 1'b1;
        repeat (3) @(negedge Clk);
        PS2_CLK = 1'b0;
        if (measure) begin
            n = 0;
            do begin
                @(posedge Clk);
                #1;
                n++;
            end while (!key_event && n < 20);
            check("evt_latency", n, 4);
        end
        repeat (6) @(negedge Clk);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (8) @(negedge Clk);
        if (kind == 0) model_byte(b);
        else exp_err++;
    endtask

    task automatic compare_state(input string tag);
        check({tag, "_kc"}, keycode, exp_kc);
        check({tag, "_ev"}, ev_cnt, exp_ev);
        check({tag, "_err"}, err_cnt, exp_err);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        exp_kc = 8'h00;
        prefix = 0;
        @(negedge Clk);
        check("rst_kc", keycode, 0);
        check("rst_ev", key_event, 0);
        check("rst_err", frame_err, 0);
    endtask

    logic [7:0] pool [0:12];

    initial begin
        int pick, kind;
        logic [7:0] b;
        pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h5A, 8'h76, 8'hE0, 8'hF0,
                 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};

        do_reset();

        // Single make with latency measurement, then its break.
        send_frame(8'h1D, 0, 1'b1);
        check("make_1d_kc", keycode, 8'h1A);
        compare_state("make_1d");
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h1D, 0, 1'b0);
        compare_state("brk_1d");

        // Typematic repeat then break.
        send_frame(8'h1D, 0, 1'b0);
        send_frame(8'h1D, 0, 1'b0);
        send_frame(8'h1D, 0, 1'b0);
        compare_state("typematic");
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h1D, 0, 1'b0);
        compare_state("typematic_brk");

        // Break of a key that is no longer the held one.
        send_frame(8'h1C, 0, 1'b0);
        check("a_kc", keycode, 8'h04);
        send_frame(8'h1B, 0, 1'b0);
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h1C, 0, 1'b0);
        check("stale_brk_kc", keycode, 8'h16);
        compare_state("stale_brk");
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h1B, 0, 1'b0);

        // Parity error, stop-bit error, bad start bit.
        send_frame(8'h5A, 1, 1'b0);
        compare_state("bad_parity");
        send_frame(8'h23, 2, 1'b0);
        compare_state("bad_stop");
        ps2_bit(1'b1);
        exp_err++;
        compare_state("bad_start");

        // Timeout after 4 data bits, then a good frame.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TMO - 30) @(negedge Clk);
        check("tmo_early", err_cnt, exp_err);
        repeat (80) @(negedge Clk);
        exp_err++;
        compare_state("timeout");
        send_frame(8'h76, 0, 1'b0);
        check("after_tmo_kc", keycode, 8'h29);
        compare_state("after_tmo");
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h76, 0, 1'b0);

        // Extended code.
        send_frame(8'hE0, 0, 1'b0);
        send_frame(8'h75, 0, 1'b0);
`ifdef PS2_ARROW_KEYS_EN
        check("ext_75_kc", keycode, 8'h1A);
`else
        check("ext_75_kc", keycode, 8'h00);
`endif
        compare_state("ext_75");
        send_frame(8'hE0, 0, 1'b0);
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h75, 0, 1'b0);
        compare_state("ext_75_brk");

        // Reset in the middle of a frame.
        send_frame(8'h23, 0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        do_reset();
        send_frame(8'h1C, 0, 1'b0);
        check("post_rst_kc", keycode, 8'h04);
        compare_state("post_rst");

        // Random byte stream with occasional corrupted frames.
        for (int k = 0; k < 120; k++) begin
            pick = $urandom_range(0, 12);
            b = pool[pick];
            if (pick == 12) b = 8'($urandom);
            kind = $urandom_range(0, 11);
            if (kind == 11) begin
                ps2_bit(1'b1);
                exp_err++;
            end else begin
                send_frame(b, (kind < 2) ? kind + 1 : 0, 1'b0);
            end
            compare_state("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
